// File: rtl/trig_capture_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : trig_capture_write_ctrl
// Purpose  : Trigger-driven write controller for the capture sample RAM.
//            Once armed, every accepted trigger emits a burst of n_write
//            contiguous RAM writes starting where the previous burst ended.
//            After n_trigger accepted triggers the controller reports done.
//            Writes stop, and overflow is flagged, once the last RAM word
//            has been written.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            arm               - pulse: latch config, clear status, start
//            n_write/n_trigger - burst length / trigger limit (read on arm)
//            trigger           - single-cycle trigger pulse
//            addr, wena        - RAM write port
//            busy, done        - acquisition status
//            n_captured        - triggers accepted since the last arm
//            trig_missed       - pulse: trigger rejected during a burst
//            overflow          - sticky: a burst was truncated, RAM full
// Revision : 1.0 - initial release
// ============================================================================
module trig_capture_write_ctrl #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic [CNT_W-1:0]  n_write,
  input  logic [CNT_W-1:0]  n_trigger,
  input  logic              trigger,
  output logic [ADDR_W-1:0] addr,
  output logic              wena,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  n_captured,
  output logic              trig_missed,
  output logic              overflow
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Write pointer is one bit wider than addr so "memory full" is visible
  // as the pointer reaching 2^ADDR_W, without ever wrapping addr itself.
  localparam logic [ADDR_W:0]   c_full    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   c_ptr_one = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  c_one     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  c_zero    = '0;

  state_t             r_state, w_state_nxt;
  logic [ADDR_W-1:0]  r_addr,  w_addr_nxt;
  logic [ADDR_W:0]    r_wptr,  w_wptr_nxt;
  logic               r_wena,  w_wena_nxt;
  logic [CNT_W-1:0]   r_cnt,   w_cnt_nxt;
  logic [CNT_W-1:0]   r_ncap,  w_ncap_nxt;
  logic [CNT_W-1:0]   r_nw,    w_nw_nxt;
  logic [CNT_W-1:0]   r_nt,    w_nt_nxt;
  logic               r_missed, w_missed_nxt;
  logic               r_ovf,   w_ovf_nxt;
  logic               r_busy,  r_done;

  logic               w_full;
  logic               w_last;
  logic [CNT_W-1:0]   w_ncap_inc;

  assign w_full     = (r_wptr == c_full);
  assign w_last     = (r_cnt == (r_nw - c_one));
  assign w_ncap_inc = r_ncap + c_one;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_addr_nxt   = r_addr;
    w_wptr_nxt   = r_wptr;
    w_wena_nxt   = 1'b0;
    w_cnt_nxt    = r_cnt;
    w_ncap_nxt   = r_ncap;
    w_nw_nxt     = r_nw;
    w_nt_nxt     = r_nt;
    w_missed_nxt = 1'b0;
    w_ovf_nxt    = r_ovf;

    if (arm) begin
      // arm wins over any trigger in the same cycle and aborts a burst.
      w_nw_nxt    = n_write;
      w_nt_nxt    = n_trigger;
      w_addr_nxt  = '0;
      w_wptr_nxt  = '0;
      w_cnt_nxt   = '0;
      w_ncap_nxt  = '0;
      w_ovf_nxt   = 1'b0;
      w_state_nxt = (n_trigger == c_zero) ? S_DONE : S_ARMED;
    end else begin
      case (r_state)
        S_ARMED: begin
          if (trigger) begin
            w_ncap_nxt = w_ncap_inc;
            w_cnt_nxt  = '0;
            if (r_nw == c_zero) begin
              w_state_nxt = (w_ncap_inc == r_nt) ? S_DONE : S_ARMED;
            end else if (w_full) begin
              w_ovf_nxt   = 1'b1;
              w_state_nxt = S_DONE;
            end else begin
              w_wena_nxt  = 1'b1;
              w_addr_nxt  = r_wptr[ADDR_W-1:0];
              w_wptr_nxt  = r_wptr + c_ptr_one;
              w_state_nxt = S_WRITE;
            end
          end
        end

        S_WRITE: begin
          if (w_last && trigger && (r_ncap != r_nt)) begin
            // Back-to-back acceptance: next burst follows with no gap.
            w_ncap_nxt = w_ncap_inc;
            w_cnt_nxt  = '0;
            if (w_full) begin
              w_ovf_nxt   = 1'b1;
              w_state_nxt = S_DONE;
            end else begin
              w_wena_nxt = 1'b1;
              w_addr_nxt = r_wptr[ADDR_W-1:0];
              w_wptr_nxt = r_wptr + c_ptr_one;
            end
          end else if (w_last) begin
            w_missed_nxt = trigger;
            w_state_nxt  = (r_ncap == r_nt) ? S_DONE : S_ARMED;
          end else begin
            w_missed_nxt = trigger;
            w_cnt_nxt    = r_cnt + c_one;
            if (w_full) begin
              // addr keeps the last written word; no wrap to 0.
              w_ovf_nxt   = 1'b1;
              w_state_nxt = S_DONE;
            end else begin
              w_wena_nxt = 1'b1;
              w_addr_nxt = r_wptr[ADDR_W-1:0];
              w_wptr_nxt = r_wptr + c_ptr_one;
            end
          end
        end

        default: begin
          // IDLE and DONE ignore triggers silently.
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr   <= '0;
      r_wptr   <= '0;
      r_wena   <= 1'b0;
      r_cnt    <= '0;
      r_ncap   <= '0;
      r_nw     <= '0;
      r_nt     <= '0;
      r_missed <= 1'b0;
      r_ovf    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_addr   <= w_addr_nxt;
      r_wptr   <= w_wptr_nxt;
      r_wena   <= w_wena_nxt;
      r_cnt    <= w_cnt_nxt;
      r_ncap   <= w_ncap_nxt;
      r_nw     <= w_nw_nxt;
      r_nt     <= w_nt_nxt;
      r_missed <= w_missed_nxt;
      r_ovf    <= w_ovf_nxt;
      r_busy   <= (w_state_nxt == S_ARMED) || (w_state_nxt == S_WRITE);
      r_done   <= (w_state_nxt == S_DONE);
    end
  end

  assign addr        = r_addr;
  assign wena        = r_wena;
  assign busy        = r_busy;
  assign done        = r_done;
  assign n_captured  = r_ncap;
  assign trig_missed = r_missed;
  assign overflow    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_trig_capture_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_trig_capture_write_ctrl
// Purpose  : Directed self-checking bench for trig_capture_write_ctrl
//            (ADDR_W=4 so the memory-full boundary is reachable). Expected
//            write addresses are queued when a trigger is driven and popped
//            whenever the DUT asserts wena.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trig_capture_write_ctrl;

  localparam int ADDR_W = 4;
  localparam int CNT_W  = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              arm;
  logic [CNT_W-1:0]  n_write;
  logic [CNT_W-1:0]  n_trigger;
  logic              trigger;
  logic [ADDR_W-1:0] addr;
  logic              wena;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  n_captured;
  logic              trig_missed;
  logic              overflow;

  trig_capture_write_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .arm(arm), .n_write(n_write), .n_trigger(n_trigger),
    .trigger(trigger), .addr(addr), .wena(wena), .busy(busy), .done(done),
    .n_captured(n_captured), .trig_missed(trig_missed), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];
  int exp_ptr = 0;
  int cur_nw  = 0;
  int n_wena  = 0;
  int n_miss  = 0;
  int run     = 0;
  int max_run = 0;
  int lat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Write-port monitor: every wena cycle consumes one queued address.
  always @(negedge clk) begin
    if (wena) begin
      n_wena++;
      run++;
      if (run > max_run) max_run = run;
      if (exp_q.size() == 0) check("wr_unexpected", {31'd0, wena}, 32'd0);
      else check("wr_addr", {28'd0, addr}, exp_q.pop_front());
    end else begin
      run = 0;
    end
    if (trig_missed) n_miss++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_counts();
    n_wena = 0; n_miss = 0; run = 0; max_run = 0;
  endtask

  task automatic do_arm(input int nw, input int nt);
    arm = 1'b1; n_write = CNT_W'(nw); n_trigger = CNT_W'(nt);
    tick();
    arm = 1'b0;
    exp_q.delete();
    exp_ptr = 0;
    cur_nw  = nw;
    clr_counts();
  endtask

  task automatic pulse_trig(input bit accept);
    if (accept) begin
      for (int i = 0; i < cur_nw; i++) begin
        if (exp_ptr < DEPTH) begin
          exp_q.push_back(exp_ptr);
          exp_ptr++;
        end
      end
    end
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int cycles);
    cycles = 0;
    while (!done && cycles < budget) begin
      tick();
      cycles++;
    end
    check(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_addr"}, {28'd0, addr}, 32'd0);
    check({tag, "_wena"}, {31'd0, wena}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_ncap"}, {24'd0, n_captured}, 32'd0);
    check({tag, "_miss"}, {31'd0, trig_missed}, 32'd0);
    check({tag, "_ovf"},  {31'd0, overflow}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; arm = 1'b0; trigger = 1'b0; n_write = '0; n_trigger = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_reset_values("reset");

    // 1: two spaced triggers, 4 words each.
    do_arm(4, 2);
    check("t1_busy", {31'd0, busy}, 32'd1);
    pulse_trig(1'b1);
    repeat (10) tick();
    check("t1_ncap_mid", {24'd0, n_captured}, 32'd1);
    check("t1_done_mid", {31'd0, done}, 32'd0);
    pulse_trig(1'b1);
    wait_done("t1_done", 20, lat);
    check("t1_done_lat", lat, 32'd4);
    check("t1_busy_end", {31'd0, busy}, 32'd0);
    check("t1_ncap", {24'd0, n_captured}, 32'd2);
    check("t1_nwena", n_wena, 32'd8);
    check("t1_q_empty", exp_q.size(), 32'd0);

    // 2: back-to-back triggers on each last write cycle.
    do_arm(3, 3);
    pulse_trig(1'b1);
    tick(); tick();
    pulse_trig(1'b1);
    tick(); tick();
    pulse_trig(1'b1);
    wait_done("t2_done", 20, lat);
    check("t2_done_lat", lat, 32'd3);
    check("t2_nwena", n_wena, 32'd9);
    check("t2_run", max_run, 32'd9);
    check("t2_nmiss", n_miss, 32'd0);
    check("t2_ncap", {24'd0, n_captured}, 32'd3);
    check("t2_q_empty", exp_q.size(), 32'd0);

    // 3: trigger on the 2nd write cycle is rejected.
    do_arm(5, 1);
    pulse_trig(1'b1);
    tick();
    pulse_trig(1'b0);
    check("t3_miss_hi", {31'd0, trig_missed}, 32'd1);
    tick();
    check("t3_miss_lo", {31'd0, trig_missed}, 32'd0);
    wait_done("t3_done", 20, lat);
    check("t3_nmiss", n_miss, 32'd1);
    check("t3_nwena", n_wena, 32'd5);
    check("t3_ncap", {24'd0, n_captured}, 32'd1);

    // 4: third burst truncated at the end of memory.
    do_arm(6, 3);
    pulse_trig(1'b1);
    repeat (8) tick();
    pulse_trig(1'b1);
    repeat (8) tick();
    pulse_trig(1'b1);
    wait_done("t4_done", 20, lat);
    check("t4_ovf", {31'd0, overflow}, 32'd1);
    check("t4_addr", {28'd0, addr}, 32'd15);
    check("t4_nwena", n_wena, 32'd16);
    check("t4_ncap", {24'd0, n_captured}, 32'd3);
    check("t4_q_empty", exp_q.size(), 32'd0);
    repeat (3) tick();
    check("t4_addr_hold", {28'd0, addr}, 32'd15);

    // 5a: n_trigger=0 goes straight to done.
    do_arm(4, 0);
    check("t5_done0", {31'd0, done}, 32'd1);
    check("t5_busy0", {31'd0, busy}, 32'd0);
    check("t5_ovf_clr", {31'd0, overflow}, 32'd0);
    pulse_trig(1'b0);
    repeat (3) tick();
    check("t5_nwena0", n_wena, 32'd0);
    check("t5_ncap0", {24'd0, n_captured}, 32'd0);
    // 5b: n_write=0 counts triggers without writing.
    do_arm(0, 2);
    check("t5_busy", {31'd0, busy}, 32'd1);
    pulse_trig(1'b1);
    check("t5_ncap1", {24'd0, n_captured}, 32'd1);
    check("t5_notdone", {31'd0, done}, 32'd0);
    pulse_trig(1'b1);
    check("t5_done", {31'd0, done}, 32'd1);
    check("t5_ncap2", {24'd0, n_captured}, 32'd2);
    check("t5_nwena", n_wena, 32'd0);

    // 6a: reset during the 3rd word of a burst.
    do_arm(5, 2);
    pulse_trig(1'b1);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_values("t6_rst");
    check("t6_q_left", exp_q.size(), 32'd2);
    exp_q.delete();
    clr_counts();
    pulse_trig(1'b0);
    repeat (3) tick();
    check("t6_idle_nwena", n_wena, 32'd0);
    check("t6_idle_ncap", {24'd0, n_captured}, 32'd0);
    check("t6_idle_busy", {31'd0, busy}, 32'd0);
    // 6b: arm mid-burst aborts and restarts at address 0.
    do_arm(5, 2);
    pulse_trig(1'b1);
    tick(); tick();
    do_arm(3, 1);
    check("t6_abort_wena", {31'd0, wena}, 32'd0);
    check("t6_abort_ncap", {24'd0, n_captured}, 32'd0);
    pulse_trig(1'b1);
    wait_done("t6_done", 20, lat);
    check("t6_nwena", n_wena, 32'd3);
    check("t6_ncap", {24'd0, n_captured}, 32'd1);
    check("t6_q_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
